// File: rtl/picomips_fetch_pkg.sv
// picomips_pkg: shared fetch-stage types, opcode width and the NOP opcode
package picomips_pkg;
    localparam int OPC_W = 6;
    localparam logic [OPC_W-1:0] NOP = 6'b000000;
    typedef enum logic [1:0] {PRIME, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/picomips_fetch_if.sv
// picomips_fetch_if: decoder/ROM-facing signals of the fetch stage; link_pc exists only with FETCH_LINK_EN
interface picomips_fetch_if #(parameter int Psize = 6, parameter int Isize = 16);
    import picomips_pkg::*;
    logic             stall;
    logic             pc_incr;
    logic             pc_abs;
    logic             pc_rel;
    logic [Psize-1:0] branch_addr;
    logic [Isize-1:0] prog_data;
    logic [Psize-1:0] prog_addr;
    logic             prog_en;
    logic [Isize-1:0] instr;
    logic             instr_valid;
    logic [OPC_W-1:0] opcode;
    logic [Psize-1:0] exec_pc;
`ifdef FETCH_LINK_EN
    logic [Psize-1:0] link_pc;
`endif
    modport master (
        output stall, pc_incr, pc_abs, pc_rel, branch_addr, prog_data,
        input  prog_addr, prog_en, instr, instr_valid, opcode, exec_pc
`ifdef FETCH_LINK_EN
        , input link_pc
`endif
    );
    modport slave (
        input  stall, pc_incr, pc_abs, pc_rel, branch_addr, prog_data,
        output prog_addr, prog_en, instr, instr_valid, opcode, exec_pc
`ifdef FETCH_LINK_EN
        , output link_pc
`endif
    );
endinterface

// File: rtl/picomips_pc_next.sv
// picomips_pc_next: combinational next-fetch-PC select; absolute beats relative, else sequential
module picomips_pc_next #(parameter int Psize = 6) (
    input  logic [Psize-1:0] i_fetch_pc,
    input  logic [Psize-1:0] i_exec_pc,
    input  logic [Psize-1:0] i_branch_addr,
    input  logic             i_en,
    input  logic             i_abs,
    input  logic             i_rel,
    output logic [Psize-1:0] o_next_pc,
    output logic             o_taken
);
    // a branch only counts while a valid instruction executes; targets wrap naturally
    always_comb begin
        o_taken   = i_en & (i_abs | i_rel);
        o_next_pc = !o_taken ? i_fetch_pc + Psize'(1)
                  : i_abs    ? i_branch_addr
                  :            i_exec_pc + i_branch_addr;
    end
endmodule

// File: rtl/picomips_fetch.sv
// picomips_fetch: picoMIPS fetch stage, one bubble per taken branch, stall support; FETCH_LINK_EN adds link_pc
module picomips_fetch #(parameter int Psize = 6, parameter int Isize = 16) (
    input logic i_clk,
    input logic i_reset,
    picomips_fetch_if.slave bus
);
    import picomips_pkg::*;
    fetch_state_t     r_state, w_state_n;
    logic [Psize-1:0] r_fetch_pc, r_exec_pc, w_fetch_n, w_exec_n, w_pc_next;
    logic             r_valid, w_valid_n, w_en, w_taken;
    assign w_en = (r_state == RUN) && r_valid && !bus.stall;
    picomips_pc_next #(.Psize(Psize)) u_pc_next (
        .i_fetch_pc    (r_fetch_pc),
        .i_exec_pc     (r_exec_pc),
        .i_branch_addr (bus.branch_addr),
        .i_en          (w_en),
        .i_abs         (bus.pc_abs),
        .i_rel         (bus.pc_rel),
        .o_next_pc     (w_pc_next),
        .o_taken       (w_taken)
    );
    // next state: PRIME/FLUSH just advance fetch; RUN either follows sequentially or redirects and flushes
    always_comb begin
        w_state_n = r_state;
        w_fetch_n = r_fetch_pc;
        w_exec_n  = r_exec_pc;
        w_valid_n = r_valid;
        if (!bus.stall) begin
            w_fetch_n = w_pc_next;
            case (r_state)
                PRIME, FLUSH: begin
                    w_valid_n = 1'b1;
                    w_state_n = RUN;
                end
                RUN: begin
                    w_exec_n  = w_taken ? w_pc_next : r_fetch_pc;
                    w_valid_n = !w_taken;
                    w_state_n = w_taken ? FLUSH : RUN;
                end
                default: begin
                    w_valid_n = 1'b0;
                    w_state_n = PRIME;
                end
            endcase
        end
    end
    // state, PC and valid registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= PRIME;
            r_fetch_pc <= '0;
            r_exec_pc  <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_n;
            r_exec_pc  <= w_exec_n;
            r_valid    <= w_valid_n;
        end
    end
`ifdef FETCH_LINK_EN
    logic [Psize-1:0] r_link_pc;
    // return address captured on a taken absolute branch
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_link_pc <= '0;
        else if (w_taken && bus.pc_abs) r_link_pc <= r_exec_pc + Psize'(1);
    end
    assign bus.link_pc = r_link_pc;
`endif
    assign bus.prog_addr   = r_fetch_pc;
    assign bus.prog_en     = !bus.stall;
    assign bus.instr       = bus.prog_data;
    assign bus.instr_valid = r_valid;
    assign bus.opcode      = r_valid ? bus.prog_data[Isize-1 -: OPC_W] : NOP;
    assign bus.exec_pc     = r_exec_pc;
endmodule
